// File: rtl/cdf_sampler_pkg.sv
// rtl/cdf_sampler_pkg.sv - shared types and constants for the inverse-CDF sampler array
package cdf_sampler_pkg;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEARCH, S_EMIT, S_FINI} state_e;

  localparam int DEF_RAND_PORTS  = 4;
  localparam int DEF_PORT_WID    = 32;
  localparam int DEF_BIT_WID     = 8;
  localparam int DEF_POSSI_S     = 32;
  localparam int DEF_RESULT_SIZE = 5;
  localparam int DEF_ROUNDS      = 1;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic int calc_lanes(input int ports, input int port_wid, input int bit_wid);
    return ports * port_wid / bit_wid;
  endfunction

  localparam int DEF_LANES = calc_lanes(DEF_RAND_PORTS, DEF_PORT_WID, DEF_BIT_WID);

endpackage

// File: rtl/cdf_sampler_array_bsearch.sv
// rtl/cdf_sampler_array_bsearch.sv - one lane: binary search of a random value over the distribution
module cdf_bsearch_lane
  import cdf_sampler_pkg::*;
#(
  parameter int BIT_WID     = DEF_BIT_WID,
  parameter int POSSI_S     = DEF_POSSI_S,
  parameter int RESULT_SIZE = DEF_RESULT_SIZE
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start_i,
  input  logic                       step_i,
  input  logic [BIT_WID-1:0]         r_i,
  input  logic [BIT_WID*POSSI_S-1:0] distr_i,
  output logic [RESULT_SIZE-1:0]     res_nxt_o,
  output logic                       sat_o
);

  logic [RESULT_SIZE-1:0] lo_q, lo_d, hi_q, hi_d, mid, mid_inc;
  logic [RESULT_SIZE:0]   sum;
  logic [BIT_WID-1:0]     tab [POSSI_S];
  logic                   go_lo;

  always_comb begin
    for (int i = 0; i < POSSI_S; i++) tab[i] = distr_i[i*BIT_WID +: BIT_WID];
  end

  assign sum     = {1'b0, lo_q} + {1'b0, hi_q};
  assign mid     = sum[RESULT_SIZE:1];
  assign mid_inc = mid + 1'b1;
  assign go_lo   = (r_i <= tab[mid]);
  assign sat_o   = (r_i > tab[POSSI_S-1]);

  // Value lo takes after the current step; sampled by the top on the final step.
  assign res_nxt_o = sat_o ? '1 : (go_lo ? lo_q : mid_inc);

  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (start_i) begin
      lo_d = '0;
      hi_d = '1;
    end else if (step_i) begin
      if (go_lo) hi_d = mid;
      else       lo_d = mid_inc;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

endmodule

// File: rtl/cdf_sampler_array.sv
// rtl/cdf_sampler_array.sv - multi-lane inverse-CDF sampler fed from the random buffer ports
module cdf_sampler_array
  import cdf_sampler_pkg::*;
#(
  parameter int  RAND_PORTS  = DEF_RAND_PORTS,
  parameter int  PORT_WID    = DEF_PORT_WID,
  parameter int  BIT_WID     = DEF_BIT_WID,
  parameter int  POSSI_S     = DEF_POSSI_S,
  parameter int  RESULT_SIZE = DEF_RESULT_SIZE,
  parameter int  ROUNDS      = DEF_ROUNDS,
  localparam int LANES       = calc_lanes(RAND_PORTS, PORT_WID, BIT_WID)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           enable,
  input  logic [BIT_WID*POSSI_S-1:0]     accu_distr,
  output logic [RAND_PORTS-1:0]          rand_rd,
  input  logic [RAND_PORTS-1:0]          rand_ready,
  input  logic [RAND_PORTS*PORT_WID-1:0] rand_data,
  output logic [RESULT_SIZE*LANES-1:0]   result,
  output logic [LANES-1:0]               sat,
  output logic                           result_valid,
  output logic                           ready,
  output logic                           done
);

  localparam int               CNT_W    = clog2(RESULT_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESULT_SIZE - 1);
  localparam logic [7:0]       ROUNDS_L = 8'(ROUNDS);

  state_e                         state_q, state_d;
  logic [RAND_PORTS-1:0]          got_q, got_d;
  logic [7:0]                     round_q, round_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [BIT_WID*POSSI_S-1:0]     distr_q;
  logic [RAND_PORTS*PORT_WID-1:0] data_q;
  logic [RESULT_SIZE*LANES-1:0]   result_q, res_nxt;
  logic [LANES-1:0]               sat_q, sat_nxt;
  logic                           snap, start, step, commit;

  always_comb begin
    state_d = state_q;
    got_d   = got_q;
    round_d = round_q;
    cnt_d   = cnt_q;
    snap    = 1'b0;
    start   = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    rand_rd = '0;
    unique case (state_q)
      S_IDLE: if (enable) begin
        snap    = 1'b1;
        round_d = '0;
        got_d   = '0;
        state_d = S_FETCH;
      end
      S_FETCH: if (!enable) begin
        state_d = S_IDLE;
      end else begin
        rand_rd = rand_ready & ~got_q;
        got_d   = got_q | rand_rd;
        if (&got_d) begin
          start   = 1'b1;
          cnt_d   = '0;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: if (!enable) begin
        state_d = S_IDLE;
      end else begin
        step = 1'b1;
        if (cnt_q == CNT_LAST) begin
          commit  = 1'b1;
          state_d = S_EMIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EMIT: begin
        got_d   = '0;
        round_d = round_q + 1'b1;
        if (!enable)                state_d = S_IDLE;
        else if (round_d == ROUNDS_L) state_d = S_FINI;
        else                        state_d = S_FETCH;
      end
      S_FINI: if (!enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Results are captured on the last search step so they appear together with result_valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      got_q    <= '0;
      round_q  <= '0;
      cnt_q    <= '0;
      distr_q  <= '0;
      data_q   <= '0;
      result_q <= '0;
      sat_q    <= '0;
    end else begin
      got_q   <= got_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
      if (snap) distr_q <= accu_distr;
      for (int p = 0; p < RAND_PORTS; p++) begin
        if (rand_rd[p]) data_q[p*PORT_WID +: PORT_WID] <= rand_data[p*PORT_WID +: PORT_WID];
      end
      if (commit) begin
        result_q <= res_nxt;
        sat_q    <= sat_nxt;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    cdf_bsearch_lane #(
      .BIT_WID    (BIT_WID),
      .POSSI_S    (POSSI_S),
      .RESULT_SIZE(RESULT_SIZE)
    ) u_lane (
      .clk      (clk),
      .rstn     (rstn),
      .start_i  (start),
      .step_i   (step),
      .r_i      (data_q[k*BIT_WID +: BIT_WID]),
      .distr_i  (distr_q),
      .res_nxt_o(res_nxt[k*RESULT_SIZE +: RESULT_SIZE]),
      .sat_o    (sat_nxt[k])
    );
  end

  assign result       = result_q;
  assign sat          = sat_q;
  assign result_valid = (state_q == S_EMIT);
  assign ready        = (state_q == S_IDLE);
  assign done         = (state_q == S_FINI);

endmodule

// File: tb/tb_cdf_sampler_array.sv
// tb/tb_cdf_sampler_array.sv - directed self-checking bench for cdf_sampler_array
module tb_cdf_sampler_array;

  logic         clk = 1'b0;
  logic         rstn, enable, en3;
  logic [255:0] accu_distr;
  logic [3:0]   rand_ready, rand_rd, rd3;
  logic [127:0] rand_data;
  logic [79:0]  result, result3;
  logic [15:0]  sat, sat3;
  logic         result_valid, ready, done, rv3, ready3, done3;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;
  int pops[4];
  int pops3[4];
  int rv_cnt   = 0;
  int rv3_q[$];
  logic [3:0] rd_log[16];
  logic s_rv, s_ready, s_done;
  int at;

  always #5 clk = ~clk;

  cdf_sampler_array dut (
    .clk(clk), .rstn(rstn), .enable(enable), .accu_distr(accu_distr),
    .rand_rd(rand_rd), .rand_ready(rand_ready), .rand_data(rand_data),
    .result(result), .sat(sat), .result_valid(result_valid), .ready(ready), .done(done)
  );

  cdf_sampler_array #(.ROUNDS(3)) dut3 (
    .clk(clk), .rstn(rstn), .enable(en3), .accu_distr(accu_distr),
    .rand_rd(rd3), .rand_ready(rand_ready), .rand_data(rand_data),
    .result(result3), .sat(sat3), .result_valid(rv3), .ready(ready3), .done(done3)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample everything at the negedge, then return just after the next posedge for driving.
  task automatic cyc();
    @(negedge clk);
    cycle++;
    for (int p = 0; p < 4; p++) begin
      if (rand_rd[p] && rand_ready[p]) pops[p]++;
      if (rd3[p] && rand_ready[p]) pops3[p]++;
    end
    if (cycle >= 0 && cycle < 16) rd_log[cycle] = rand_rd;
    if (result_valid) rv_cnt++;
    if (rv3) rv3_q.push_back(cycle);
    s_rv    = result_valid;
    s_ready = ready;
    s_done  = done;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] uniform_distr();
    logic [255:0] a;
    for (int i = 0; i < 32; i++) a[i*8 +: 8] = 8'(8 * i + 7);
    return a;
  endfunction

  function automatic logic [255:0] ident_distr();
    logic [255:0] a;
    for (int i = 0; i < 32; i++) a[i*8 +: 8] = 8'(i);
    return a;
  endfunction

  function automatic logic [79:0] lanes4(input logic [4:0] a, b, c, d);
    logic [79:0] v;
    for (int k = 0; k < 16; k += 4) begin
      v[k*5 +: 5]      = a;
      v[(k+1)*5 +: 5]  = b;
      v[(k+2)*5 +: 5]  = c;
      v[(k+3)*5 +: 5]  = d;
    end
    return v;
  endfunction

  task automatic begin_run();
    for (int p = 0; p < 4; p++) pops[p] = 0;
    enable = 1'b1;
    cycle  = -1;
  endtask

  task automatic wait_rv(input int bound, output int when);
    when = -1;
    for (int i = 0; i < bound && when < 0; i++) begin
      cyc();
      if (s_rv) when = cycle;
    end
  endtask

  task automatic finish_run(input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      cyc();
      if (s_done) seen = 1;
    end
    check({tag, "_done"}, 128'(seen), 128'd1);
    enable = 1'b0;
    cyc();
    cyc();
    check({tag, "_idle"}, {s_ready, s_done}, 2'b10);
  endtask

  task automatic check_pops(input string tag, input int exp);
    check(tag, {32'(pops[3]), 32'(pops[2]), 32'(pops[1]), 32'(pops[0])},
          {32'(exp), 32'(exp), 32'(exp), 32'(exp)});
  endtask

  initial begin
    rstn       = 1'b0;
    enable     = 1'b0;
    en3        = 1'b0;
    rand_ready = 4'hF;
    rand_data  = {4{32'hFF080700}};
    accu_distr = uniform_distr();
    cyc();
    cyc();
    check("rst_outs", {result, sat, s_rv, s_ready, s_done, rand_rd}, {80'h0, 16'h0, 3'b010, 4'h0});
    rstn = 1'b1;
    cyc();

    // uniform distribution, bytes 00/07/08/FF
    begin_run();
    wait_rv(30, at);
    check("t1_latency", 128'(at), 128'd7);
    check("t1_result", result, lanes4(5'd0, 5'd0, 5'd1, 5'd31));
    check("t1_sat", sat, 16'h0);
    check("t1_rd_fetch", {rd_log[1], rd_log[2]}, {4'hF, 4'h0});
    check_pops("t1_pops", 1);
    finish_run("t1");

    // every entry saturated-high: all lanes hit index 0
    accu_distr = {32{8'hFF}};
    rand_data  = {4{32'hA5A5A5A5}};
    begin_run();
    wait_rv(30, at);
    check("t2_result", {result, sat}, {80'h0, 16'h0});
    finish_run("t2");

    // accu[i]=i, value above the last entry saturates
    accu_distr = ident_distr();
    rand_data  = {4{32'h80808080}};
    begin_run();
    wait_rv(30, at);
    check("t3_result", result, {80{1'b1}});
    check("t3_sat", sat, 16'hFFFF);
    finish_run("t3");

    // boundary around the last entry: 0x1F fits, 0x20 saturates
    rand_data = {4{32'h201F0500}};
    begin_run();
    wait_rv(30, at);
    check("t4_result", result, lanes4(5'd0, 5'd5, 5'd31, 5'd31));
    check("t4_sat", sat, 16'h8888);
    finish_run("t4");

    // snapshot: distribution changed after start must not matter
    accu_distr = uniform_distr();
    rand_data  = {4{32'hFF080700}};
    begin_run();
    cyc();
    accu_distr = {32{8'hFF}};
    wait_rv(30, at);
    check("t5_snapshot", result, lanes4(5'd0, 5'd0, 5'd1, 5'd31));
    finish_run("t5");
    accu_distr = uniform_distr();

    // port 2 stalled for three fetch cycles
    rand_ready = 4'b1011;
    begin_run();
    cyc();
    cyc();
    cyc();
    cyc();
    rand_ready = 4'hF;
    wait_rv(30, at);
    check("t6_latency", 128'(at), 128'd10);
    check("t6_rd_seq", {rd_log[1], rd_log[2], rd_log[3], rd_log[4]}, {4'b1011, 4'h0, 4'h0, 4'b0100});
    check_pops("t6_pops", 1);
    finish_run("t6");

    // three rounds on the second instance
    for (int p = 0; p < 4; p++) pops3[p] = 0;
    rv3_q.delete();
    en3   = 1'b1;
    cycle = -1;
    for (int i = 0; i < 30; i++) cyc();
    check("t7_rv_count", 128'(rv3_q.size()), 128'd3);
    if (rv3_q.size() == 3)
      check("t7_rv_cycles", {32'(rv3_q[0]), 32'(rv3_q[1]), 32'(rv3_q[2])}, {32'd7, 32'd14, 32'd21});
    check("t7_pops", {32'(pops3[3]), 32'(pops3[2]), 32'(pops3[1]), 32'(pops3[0])},
          {32'd3, 32'd3, 32'd3, 32'd3});
    check("t7_done_held", {done3, ready3, result3}, {2'b10, lanes4(5'd0, 5'd0, 5'd1, 5'd31)});
    en3 = 1'b0;
    cyc();
    cyc();
    check("t7_idle", {done3, ready3}, 2'b01);

    // abort on the second search cycle
    rand_data = {4{32'h00000000}};
    at        = rv_cnt;
    begin_run();
    cyc();
    cyc();
    cyc();
    enable = 1'b0;
    cyc();
    cyc();
    check("t8_abort_idle", 128'(s_ready), 128'd1);
    for (int i = 0; i < 8; i++) cyc();
    check("t8_no_rv", 128'(rv_cnt), 128'(at));
    check("t8_result_kept", result, lanes4(5'd0, 5'd0, 5'd1, 5'd31));
    rand_data = {4{32'h201F0500}};
    accu_distr = ident_distr();
    begin_run();
    wait_rv(30, at);
    check("t8_rerun", {result, sat}, {lanes4(5'd0, 5'd5, 5'd31, 5'd31), 16'h8888});
    finish_run("t8");

    // asynchronous reset with two ports captured
    accu_distr = uniform_distr();
    rand_data  = {4{32'hFF080700}};
    rand_ready = 4'b0011;
    begin_run();
    cyc();
    cyc();
    cyc();
    rstn       = 1'b0;
    rand_ready = 4'b1100;
    enable     = 1'b0;
    #1;
    check("t9_rst_outs", {result, sat, result_valid, ready, done, rand_rd}, {80'h0, 16'h0, 3'b010, 4'h0});
    cyc();
    rstn       = 1'b1;
    rand_ready = 4'hF;
    cyc();
    begin_run();
    wait_rv(30, at);
    check("t9_fresh", {128'(at), result}, {128'd7, lanes4(5'd0, 5'd0, 5'd1, 5'd31)});
    finish_run("t9");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
